// File: rtl/operand_fetch_pkg.sv
// Shared core constants and helpers for the operand fetch stage.
package operand_fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREGS = 32;
  localparam int REGW = 5;

  typedef logic [REGW-1:0] regIdx_t;
  typedef logic [NREGS-1:0] regMask_t;

  localparam regIdx_t ZERO_REG = '0;

  function automatic regMask_t idxMask(
    input regIdx_t idx
  );
    regMask_t m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side, regfile, writeback and execute-side
// signals of the operand fetch stage.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CTRLW = 16
);
  logic in_valid;
  logic in_ready;
  logic [REGW-1:0] in_rs1;
  logic [REGW-1:0] in_rs2;
  logic [REGW-1:0] in_rd;
  logic in_use_rs1;
  logic in_use_rs2;
  logic in_rd_we;
  logic [XLEN-1:0] in_imm;
  logic [CTRLW-1:0] in_ctrl;

  logic [REGW-1:0] rf_raddr1;
  logic [REGW-1:0] rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;

  logic wb_valid;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  logic flush;

  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_imm;
  logic [REGW-1:0] out_rd;
  logic out_rd_we;
  logic [CTRLW-1:0] out_ctrl;

  modport slave (
    input in_valid, in_rs1, in_rs2, in_rd,
    input in_use_rs1, in_use_rs2, in_rd_we,
    input in_imm, in_ctrl,
    output in_ready,
    output rf_raddr1, rf_raddr2,
    input rf_rdata1, rf_rdata2,
    input wb_valid, wb_rd, wb_data,
    input flush,
    output out_valid,
    input out_ready,
    output out_op1, out_op2, out_imm,
    output out_rd, out_rd_we, out_ctrl
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd,
    output in_use_rs1, in_use_rs2, in_rd_we,
    output in_imm, in_ctrl,
    input in_ready,
    input rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2,
    output wb_valid, wb_rd, wb_data,
    output flush,
    input out_valid,
    output out_ready,
    input out_op1, out_op2, out_imm,
    input out_rd, out_rd_we, out_ctrl
  );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// Register busy scoreboard: clear mask applied first,
// then a single set that wins on the same index.
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     setEn,
  input  regIdx_t  setIdx,
  input  regMask_t clrMask,
  output regMask_t busy
);

  regMask_t busyNxt;

  always_comb begin
    busyNxt = busy & ~clrMask;
    if (setEn) begin
      busyNxt = busyNxt | idxMask(setIdx);
    end
    busyNxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busyNxt;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard check, writeback bypass
// and a one-entry output register toward execute.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CTRLW = 16
) (
  input logic clk,
  input logic rst_n,
  operand_fetch_if.slave bus
);

  regMask_t busy;
  regMask_t clrMask;

  logic wbHit;
  logic hit1;
  logic hit2;
  logic hitRd;
  logic rs1Rdy;
  logic rs2Rdy;
  logic rdRdy;
  logic outFree;
  logic inReady;
  logic accept;
  logic setEn;

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  logic outValid;
  logic [XLEN-1:0] outOp1;
  logic [XLEN-1:0] outOp2;
  logic [XLEN-1:0] outImm;
  regIdx_t outRd;
  logic outRdWe;
  logic [CTRLW-1:0] outCtrl;

  assign bus.rf_raddr1 = bus.in_rs1;
  assign bus.rf_raddr2 = bus.in_rs2;

  // x0 writebacks neither bypass nor touch the scoreboard
  assign wbHit = bus.wb_valid && (bus.wb_rd != ZERO_REG);
  assign hit1 = wbHit && (bus.wb_rd == bus.in_rs1);
  assign hit2 = wbHit && (bus.wb_rd == bus.in_rs2);
  assign hitRd = wbHit && (bus.wb_rd == bus.in_rd);

  assign rs1Rdy = !bus.in_use_rs1
               || (bus.in_rs1 == ZERO_REG)
               || !busy[bus.in_rs1]
               || hit1;
  assign rs2Rdy = !bus.in_use_rs2
               || (bus.in_rs2 == ZERO_REG)
               || !busy[bus.in_rs2]
               || hit2;
  assign rdRdy = !bus.in_rd_we
              || (bus.in_rd == ZERO_REG)
              || !busy[bus.in_rd]
              || hitRd;

  assign outFree = !outValid || bus.out_ready;
  assign inReady = rst_n && outFree && rs1Rdy
                && rs2Rdy && rdRdy && !bus.flush;
  assign accept = bus.in_valid && inReady;
  assign bus.in_ready = inReady;

  always_comb begin
    op1 = bus.rf_rdata1;
    op2 = bus.rf_rdata2;
    if (bus.in_rs1 == ZERO_REG) begin
      op1 = '0;
    end else if (hit1) begin
      op1 = bus.wb_data;
    end
    if (bus.in_rs2 == ZERO_REG) begin
      op2 = '0;
    end else if (hit2) begin
      op2 = bus.wb_data;
    end
  end

  // a flushed instruction never reaches writeback,
  // so release its destination here
  always_comb begin
    clrMask = '0;
    if (wbHit) begin
      clrMask = clrMask | idxMask(bus.wb_rd);
    end
    if (bus.flush && outValid && outRdWe) begin
      clrMask = clrMask | idxMask(outRd);
    end
  end

  assign setEn = accept && bus.in_rd_we
              && (bus.in_rd != ZERO_REG);

  reg_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .setEn   (setEn),
    .setIdx  (bus.in_rd),
    .clrMask (clrMask),
    .busy    (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      outOp1 <= '0;
      outOp2 <= '0;
      outImm <= '0;
      outRd <= '0;
      outRdWe <= 1'b0;
      outCtrl <= '0;
    end else if (accept) begin
      outValid <= 1'b1;
      outOp1 <= op1;
      outOp2 <= op2;
      outImm <= bus.in_imm;
      outRd <= bus.in_rd;
      outRdWe <= bus.in_rd_we;
      outCtrl <= bus.in_ctrl;
    end else if (bus.flush) begin
      outValid <= 1'b0;
    end else if (outValid && bus.out_ready) begin
      outValid <= 1'b0;
    end
  end

  assign bus.out_valid = outValid;
  assign bus.out_op1 = outOp1;
  assign bus.out_op2 = outOp2;
  assign bus.out_imm = outImm;
  assign bus.out_rd = outRd;
  assign bus.out_rd_we = outRdWe;
  assign bus.out_ctrl = outCtrl;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a queue-based
// scoreboard checking every transfer to execute.
module tb_operand_fetch;

  logic clk;
  logic rst_n;

  int nVec;
  int nMiss;
  int nXfer;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0] rd;
    logic we;
    logic [15:0] ctrl;
  } exp_t;

  exp_t q[$];

  operand_fetch_if #(.XLEN(32), .CTRLW(16)) bus ();

  operand_fetch #(.XLEN(32), .CTRLW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_rd = '0;
    bus.in_use_rs1 = 1'b0;
    bus.in_use_rs2 = 1'b0;
    bus.in_rd_we = 1'b0;
    bus.in_imm = '0;
    bus.in_ctrl = '0;
    bus.rf_rdata1 = '0;
    bus.rf_rdata2 = '0;
    bus.wb_valid = 1'b0;
    bus.wb_rd = '0;
    bus.wb_data = '0;
    bus.flush = 1'b0;
  endtask

  task automatic issue(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic [4:0] rd,
    input logic u1,
    input logic u2,
    input logic we,
    input logic [31:0] imm,
    input logic [15:0] ctrl,
    input logic [31:0] d1,
    input logic [31:0] d2
  );
    bus.in_valid = 1'b1;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_rd = rd;
    bus.in_use_rs1 = u1;
    bus.in_use_rs2 = u2;
    bus.in_rd_we = we;
    bus.in_imm = imm;
    bus.in_ctrl = ctrl;
    bus.rf_rdata1 = d1;
    bus.rf_rdata2 = d2;
  endtask

  task automatic push(
    input logic [31:0] op1,
    input logic [31:0] op2,
    input logic [31:0] imm,
    input logic [4:0] rd,
    input logic we,
    input logic [15:0] ctrl
  );
    exp_t e;
    e.op1 = op1;
    e.op2 = op2;
    e.imm = imm;
    e.rd = rd;
    e.we = we;
    e.ctrl = ctrl;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      exp_t e;
      nXfer++;
      if (q.size() == 0) begin
        check("unexpected_xfer", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("xfer_op1", bus.out_op1, e.op1);
        check("xfer_op2", bus.out_op2, e.op2);
        check("xfer_imm", bus.out_imm, e.imm);
        check("xfer_rd", {bus.out_rd, bus.out_rd_we},
              {e.rd, e.we});
        check("xfer_ctrl", bus.out_ctrl, e.ctrl);
      end
    end
  end

  initial begin
    nVec = 0;
    nMiss = 0;
    nXfer = 0;
    rst_n = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", dut.busy, 0);
    check("rst_op1", bus.out_op1, 0);
    check("rst_op2", bus.out_op2, 0);
    check("rst_imm", bus.out_imm, 0);
    check("rst_rd", {bus.out_rd, bus.out_rd_we}, 0);
    check("rst_ctrl", bus.out_ctrl, 0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // basic issue
    issue(1, 2, 3, 1, 1, 1, 32'h11, 16'h0A01, 5, 7);
    push(5, 7, 32'h11, 3, 1, 16'h0A01);
    @(negedge clk);
    check("t1_in_ready", bus.in_ready, 1);
    check("t1_raddr", {bus.rf_raddr1, bus.rf_raddr2},
          {5'd1, 5'd2});
    tick();
    idle();
    @(negedge clk);
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_busy", dut.busy, 32'h8);
    tick();

    // RAW stall released by same-cycle writeback
    issue(3, 0, 6, 1, 0, 0, 32'h22, 16'h0B02,
          32'h1111, 32'h9999);
    @(negedge clk);
    check("t2_stall", bus.in_ready, 0);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rd = 5'd3;
    bus.wb_data = 32'hDEAD;
    push(32'hDEAD, 0, 32'h22, 6, 0, 16'h0B02);
    @(negedge clk);
    check("t2_bypass_ready", bus.in_ready, 1);
    tick();
    idle();
    @(negedge clk);
    check("t2_busy", dut.busy, 0);
    check("t2_out_valid", bus.out_valid, 1);
    tick();

    // backpressure then back-to-back
    bus.out_ready = 1'b0;
    issue(7, 8, 9, 1, 1, 1, 32'h33, 16'h0033,
          32'h70, 32'h80);
    push(32'h70, 32'h80, 32'h33, 9, 1, 16'h0033);
    @(negedge clk);
    check("t3_a_ready", bus.in_ready, 1);
    tick();
    issue(10, 11, 12, 1, 1, 1, 32'h44, 16'h0044,
          32'hA0, 32'hB0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_hold_ready", bus.in_ready, 0);
      check("t3_hold_valid", bus.out_valid, 1);
      check("t3_hold_op1", bus.out_op1, 32'h70);
      check("t3_hold_imm", bus.out_imm, 32'h33);
      tick();
    end
    bus.out_ready = 1'b1;
    push(32'hA0, 32'hB0, 32'h44, 12, 1, 16'h0044);
    @(negedge clk);
    check("t3_b2b_ready", bus.in_ready, 1);
    tick();
    idle();
    @(negedge clk);
    check("t3_b_valid", bus.out_valid, 1);
    check("t3_busy", dut.busy, 32'h1200);
    tick();

    // x0 destination/source, x0 writeback ignored
    issue(0, 2, 0, 1, 0, 1, 32'h55, 16'h0055,
          32'hFFFFFFFF, 32'h22);
    bus.wb_valid = 1'b1;
    bus.wb_rd = 5'd0;
    bus.wb_data = 32'h5555;
    push(0, 32'h22, 32'h55, 0, 1, 16'h0055);
    @(negedge clk);
    check("t4_ready", bus.in_ready, 1);
    tick();
    idle();
    @(negedge clk);
    check("t4_busy", dut.busy, 32'h1200);
    tick();

    // flush of held instruction with writeback
    bus.out_ready = 1'b0;
    issue(1, 2, 5, 1, 1, 1, 32'h66, 16'h0066, 1, 2);
    @(negedge clk);
    check("t5_ready", bus.in_ready, 1);
    tick();
    issue(13, 14, 13, 1, 1, 1, 32'h67, 16'h0067, 1, 2);
    bus.flush = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd = 5'd9;
    bus.wb_data = 32'h99;
    @(negedge clk);
    check("t5_flush_ready", bus.in_ready, 0);
    check("t5_busy_pre", dut.busy, 32'h1220);
    tick();
    idle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t5_flush_valid", bus.out_valid, 0);
    check("t5_busy_post", dut.busy, 32'h1000);
    tick();

    // WAW resolved by same-cycle writeback
    issue(0, 0, 4, 0, 0, 1, 32'h77, 16'h0077, 0, 0);
    push(0, 0, 32'h77, 4, 1, 16'h0077);
    @(negedge clk);
    check("t6_ready", bus.in_ready, 1);
    tick();
    idle();
    @(negedge clk);
    check("t6_busy", dut.busy, 32'h1010);
    tick();
    issue(0, 4, 4, 0, 1, 1, 32'h88, 16'h0088, 0, 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd = 5'd4;
    bus.wb_data = 32'h4444;
    push(0, 32'h4444, 32'h88, 4, 1, 16'h0088);
    @(negedge clk);
    check("t6_waw_wb_ready", bus.in_ready, 1);
    tick();
    idle();
    @(negedge clk);
    check("t6_set_wins", dut.busy, 32'h1010);
    tick();
    issue(0, 0, 12, 0, 0, 1, 32'h99, 16'h0099, 0, 0);
    @(negedge clk);
    check("t6_waw_stall", bus.in_ready, 0);
    tick();
    idle();

    // reset while an instruction is held
    bus.out_ready = 1'b0;
    issue(1, 2, 20, 1, 1, 1, 32'hAA, 16'h00AA, 3, 4);
    @(negedge clk);
    check("t7_ready", bus.in_ready, 1);
    tick();
    idle();
    @(negedge clk);
    check("t7_held", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", bus.out_valid, 0);
    check("t7_rst_busy", dut.busy, 0);
    check("t7_rst_ready", bus.in_ready, 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    check("queue_empty", q.size(), 0);
    check("xfer_count", nXfer, 7);
    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nMiss);
    $finish;
  end

endmodule
